// File: rtl/uds_pkg.sv
// Shared constants for the UDS key fetch block: UDS core word addresses,
// the two expected name words, the FSM state encoding and the default
// ready timeout.
package uds_pkg;

    localparam logic [7:0]  UDS_ADDR_NAME0     = 8'h00;
    localparam logic [7:0]  UDS_ADDR_NAME1     = 8'h01;
    localparam logic [7:0]  UDS_ADDR_KEY_FIRST = 8'h10;
    localparam logic [7:0]  UDS_ADDR_KEY_LAST  = 8'h17;

    localparam logic [31:0] UDS_NAME0_WORD = 32'h7564735f;
    localparam logic [31:0] UDS_NAME1_WORD = 32'h6d656d20;

    localparam int UDS_DEFAULT_TIMEOUT = 16;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_NAME0  = 3'd1;
    localparam logic [2:0] ST_NAME1  = 3'd2;
    localparam logic [2:0] ST_READ   = 3'd3;
    localparam logic [2:0] ST_STREAM = 3'd4;
    localparam logic [2:0] ST_DONE   = 3'd5;
    localparam logic [2:0] ST_ERR    = 3'd6;

    // Key words sit in a contiguous window starting at UDS_ADDR_KEY_FIRST.
    function automatic logic [7:0] uds_key_addr(input logic [2:0] word_idx);
        return UDS_ADDR_KEY_FIRST + {5'd0, word_idx};
    endfunction

endpackage

// File: rtl/uds_fetch_buf.sv
// 8 x 32-bit key buffer: one write port, one asynchronous read port and a
// synchronous wipe that clears every entry at once.
module uds_fetch_buf (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        wipe,
    input  logic        wr_en,
    input  logic [2:0]  wr_addr,
    input  logic [31:0] wr_data,
    input  logic [2:0]  rd_addr,
    output logic [31:0] rd_data
);

    logic [31:0] mem [0:7];

    // Reset and wipe zero the whole array; otherwise store one word per write.
    always_ff @(posedge clk) begin
        if (!reset_n || wipe) begin
            for (int i = 0; i < 8; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/uds_fetch.sv
// UDS key fetch: reads eight key words from the read-once UDS core into a
// local buffer, then streams them out over a valid/ready interface.
// The buffer is wiped as soon as the stream ends or the fetch fails.
// Optional build macro UDS_FETCH_NAME_CHECK_EN adds a two-word name check
// (addresses 0x00/0x01) before the key words are read.
module uds_fetch
    import uds_pkg::*;
#(
    parameter int TIMEOUT = UDS_DEFAULT_TIMEOUT
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic        clear,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic        uds_cs,
    output logic [7:0]  uds_address,
    input  logic [31:0] uds_read_data,
    input  logic        uds_ready,
    output logic        key_valid,
    input  logic        key_ready,
    output logic [31:0] key_word,
    output logic [2:0]  key_index,
    output logic        key_last
);

    localparam int               WAIT_W    = $clog2(TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

    logic [2:0]        state_q;
    logic [2:0]        state_d;
    logic [2:0]        rd_cnt_q;
    logic [2:0]        idx_q;
    logic [WAIT_W-1:0] wait_q;
    logic              error_q;

    logic              capture;
    logic              stream_xfer;
    logic              wait_step;
    logic              fail;
    logic              finish;
    logic              name_phase;
    logic              buf_wipe;
    logic [31:0]       buf_rd_data;

    // Next-state decode; a wait that reaches the timeout turns into a failure.
    always_comb begin
        state_d     = state_q;
        capture     = 1'b0;
        stream_xfer = 1'b0;
        wait_step   = 1'b0;
        fail        = 1'b0;
        finish      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
`ifdef UDS_FETCH_NAME_CHECK_EN
                    state_d = ST_NAME0;
`else
                    state_d = ST_READ;
`endif
                end
            end
`ifdef UDS_FETCH_NAME_CHECK_EN
            ST_NAME0: begin
                if (uds_ready) begin
                    if (uds_read_data == UDS_NAME0_WORD) begin
                        state_d = ST_NAME1;
                    end else begin
                        fail = 1'b1;
                    end
                end else begin
                    wait_step = 1'b1;
                end
            end
            ST_NAME1: begin
                if (uds_ready) begin
                    if (uds_read_data == UDS_NAME1_WORD) begin
                        state_d = ST_READ;
                    end else begin
                        fail = 1'b1;
                    end
                end else begin
                    wait_step = 1'b1;
                end
            end
`endif
            ST_READ: begin
                if (uds_ready) begin
                    capture = 1'b1;
                    if (uds_address == UDS_ADDR_KEY_LAST) begin
                        state_d = ST_STREAM;
                    end
                end else begin
                    wait_step = 1'b1;
                end
            end
            ST_STREAM: begin
                if (key_ready) begin
                    stream_xfer = 1'b1;
                    if (idx_q == 3'd7) begin
                        state_d = ST_DONE;
                        finish  = 1'b1;
                    end
                end
            end
            default: begin
            end
        endcase
        if (wait_step && (wait_q == WAIT_LAST)) begin
            fail = 1'b1;
        end
        if (fail) begin
            state_d = ST_ERR;
        end
    end

    // FSM state, word counters and sticky error; clear behaves like reset.
    always_ff @(posedge clk) begin
        if (!reset_n || clear) begin
            state_q  <= ST_IDLE;
            rd_cnt_q <= 3'd0;
            idx_q    <= 3'd0;
            error_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (capture) begin
                rd_cnt_q <= rd_cnt_q + 3'd1;
            end
            if (stream_xfer) begin
                idx_q <= idx_q + 3'd1;
            end
            if (fail) begin
                error_q <= 1'b1;
            end
        end
    end

    // Ready-wait counter restarts whenever a read completes or no read is pending.
    always_ff @(posedge clk) begin
        if (!reset_n || clear) begin
            wait_q <= '0;
        end else if (wait_step && !fail) begin
            wait_q <= wait_q + 1'b1;
        end else begin
            wait_q <= '0;
        end
    end

`ifdef UDS_FETCH_NAME_CHECK_EN
    assign name_phase = (state_q == ST_NAME0) || (state_q == ST_NAME1);
`else
    assign name_phase = 1'b0;
`endif

    // Drive the UDS word address for whichever read is currently issued.
    always_comb begin
        uds_address = 8'h00;
        if (state_q == ST_READ) begin
            uds_address = uds_key_addr(rd_cnt_q);
        end
`ifdef UDS_FETCH_NAME_CHECK_EN
        else if (state_q == ST_NAME0) begin
            uds_address = UDS_ADDR_NAME0;
        end else if (state_q == ST_NAME1) begin
            uds_address = UDS_ADDR_NAME1;
        end
`endif
    end

    assign buf_wipe = fail || finish || clear;

    uds_fetch_buf u_buf (
        .clk     (clk),
        .reset_n (reset_n),
        .wipe    (buf_wipe),
        .wr_en   (capture && !clear),
        .wr_addr (rd_cnt_q),
        .wr_data (uds_read_data),
        .rd_addr (idx_q),
        .rd_data (buf_rd_data)
    );

    assign busy      = (state_q != ST_IDLE) && (state_q != ST_DONE);
    assign done      = (state_q == ST_DONE);
    assign error     = error_q;
    assign uds_cs    = (state_q == ST_READ) || name_phase;
    assign key_valid = (state_q == ST_STREAM);
    assign key_word  = key_valid ? buf_rd_data : 32'h0;
    assign key_index = idx_q;
    assign key_last  = key_valid && (idx_q == 3'd7);

endmodule

// File: doc/uds_fetch.md
UDS_FETCH -- requirements
Module: uds_fetch

Interface
REQ-001 The module SHALL have these ports (clock and reset first):
- clk  in  1  system clock
- reset_n  in  1  reset; synchronous, active-low; clock clk
- start  in  1  one-cycle pulse; begin a fetch
- clear  in  1  one-cycle pulse; wipe the buffer and return to IDLE
- busy  out  1  high in every state except IDLE and DONE
- done  out  1  high in DONE
- error  out  1  sticky fetch-failure flag
- uds_cs  out  1  read strobe to the UDS core
- uds_address  out  8  UDS core word address
- uds_read_data  in  32  UDS core read data
- uds_ready  in  1  UDS core ready, combinational with uds_cs
- key_valid  out  1  stream word valid
- key_ready  in  1  stream word accepted
- key_word  out  32  stream data
- key_index  out  3  word index, 0..7
- key_last  out  1  high with index 7

REQ-002 The module SHALL have one parameter: TIMEOUT, default 16, the maximum number of cycles spent waiting for uds_ready per read.

Function
REQ-003 The FSM SHALL have the states IDLE, NAME0, NAME1, READ, STREAM, DONE and ERR.
REQ-004 In IDLE, start SHALL cause a transition to NAME0 if UDS_FETCH_NAME_CHECK_EN is defined, and to READ otherwise.
REQ-005 In NAME0 and NAME1, uds_cs SHALL be driven high with address 0x00 and 0x01 respectively; read_data SHALL be compared with 0x7564735f and 0x6d656d20.
REQ-006 A name mismatch SHALL cause a transition to ERR; a match SHALL advance NAME0 -> NAME1 -> READ.
REQ-007 In READ, a 3-bit counter SHALL drive uds_address = 0x10 + counter with uds_cs high for one cycle per word.
REQ-008 uds_read_data SHALL be captured into buffer[counter] in the cycle uds_ready is high; the counter SHALL then increment.
REQ-009 After word 7 is captured, READ SHALL transition to STREAM; each UDS word SHALL be read exactly once (the source is read-once).
REQ-010 The wait counter SHALL reset on every issued read; if uds_ready stays low for TIMEOUT consecutive cycles, the FSM SHALL transition to ERR.
REQ-011 In STREAM, key_valid SHALL be high, key_word = buffer[idx], key_index = idx and key_last = (idx == 7).
REQ-012 On key_valid && key_ready, idx SHALL advance; after the transfer with idx 7, STREAM SHALL go to DONE.
REQ-013 key_word SHALL be held stable while key_valid is high and key_ready is low.
REQ-014 On entering DONE or ERR, the buffer SHALL be zeroed in that same cycle; key_word SHALL read 0 whenever key_valid is low.
REQ-015 In ERR, error SHALL be 1; it SHALL remain 1 until clear or reset.
REQ-016 start SHALL be ignored outside IDLE.
REQ-017 clear SHALL take priority over start and over all handshakes; in any state it SHALL zero the buffer, idx, counter and error and enter IDLE on the next cycle.
REQ-018 A zero UDS word SHALL be treated as valid data, not as an error.

Reset
REQ-019 While reset_n is low on a clk edge, the FSM SHALL go to IDLE and the buffer, counters and error SHALL be zeroed.
REQ-020 Reset values SHALL be: busy 0, done 0, error 0, uds_cs 0, uds_address 0x00, key_valid 0, key_word 0, key_index 0, key_last 0.
REQ-021 Reset mid-fetch SHALL abandon the fetch; UDS words already read are not re-requested.

Configuration
REQ-022 The macro UDS_FETCH_NAME_CHECK_EN SHALL control the name check.
REQ-023 With UDS_FETCH_NAME_CHECK_EN defined, NAME0 and NAME1 SHALL be compiled in and the fetch SHALL take 2 extra reads.
REQ-024 Without UDS_FETCH_NAME_CHECK_EN, those states and comparators SHALL be absent, and IDLE SHALL go directly to READ.

Structure
REQ-025 A shared package uds_pkg SHALL hold:
- the address constants 0x00, 0x01, 0x10 and 0x17
- the name constants
- the FSM state encoding
- the default TIMEOUT
REQ-026 One sub-module, uds_fetch_buf, SHALL implement the 8x32 buffer with write port, read port and synchronous wipe.

Verification
REQ-027 The bench SHALL cover these directed scenarios:
- Macro off, UDS model words 0x11..0x88, start, key_ready=1 -> 8 reads at 0x10..0x17, then words streamed in order; key_last with 0x88; done=1; buffer reads zero.
- key_ready low for 3 cycles at idx 2 -> key_word holds buffer[2] and idx does not advance.
- Macro on, NAME0 returns 0xdeadbeef -> no access to 0x10..0x17; error=1; clear -> error=0 and FSM in IDLE.
- uds_ready tied low -> ERR after exactly 16 cycles; uds_cs deasserted.
- clear at idx 4 during STREAM -> key_valid=0 on the next cycle and all buffer entries 0.
- start while busy -> ignored, and the sequence still completes after exactly 8 reads.
